fp_to_int: RTL
==============

Name: fp_to_int

Overview:
- Converts an IEEE-754 binary32 value to a 32-bit signed or unsigned integer. It is the FP-to-integer direction of the FP unit, the counterpart of the integer-to-FP encode path.
- Uses the same five rounding modes and the same exception flag semantics as the FP adder.
- Two-stage elastic pipeline with valid/ready on both sides; sits between the operand mux and the integer writeback of the FP datapath.

Parameters:
- W, 32, input float width and output integer width.
- M, 22, MSB index of the stored mantissa field.
- E, 30, MSB index of the exponent field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready.
- in1  in  W  binary32 operand.
- round_m  in  3  rounding mode, captured with in1: RNe=000, RZ=001, RD=010, RU=011, RNa=100; other codes behave as RZ.
- signed_m  in  1  1 = signed int32 result, 0 = unsigned uint32; captured with in1.
- out  out  W  integer result.
- out_valid  out  1  result valid; held stable until out_ready.
- out_ready  in  1  downstream accepts.
- inv  out  1  invalid flag, qualified by out_valid.
- inexact  out  1  inexact flag, qualified by out_valid.

Behaviour:
- Reset: out=0, out_valid=0, inv=0, inexact=0, both stage-valid bits 0. Reset takes effect immediately, even mid-operation; in-flight operands are discarded, and in_ready=1 once reset is released.
- Stage 1 (unpack/align) registers:
  - sign, special class (zero, denormal, inf, NaN, overflow);
  - 32-bit integer part of {1, mant} shifted by (exp-127);
  - guard bit g and sticky t;
  - round_m and signed_m.
- Stage 2 (round/negate/saturate) registers out, inv and inexact.
- Handshake:
  - s2_free = !v2 | out_ready; in_ready = !v1 | s2_free (combinational).
  - Stage 1 advances into stage 2 when v1 & s2_free.
  - Latency is 2 cycles from the accepting edge to out_valid when there is no stall; throughput is 1 per cycle.
- Stall: while out_valid & !out_ready, out, inv and inexact hold. At most 2 operands are in flight.
- Alignment:
  - ue = exp-127.
  - ue<0: integer part 0; g = (ue==-1); t = the remaining bits.
  - 0<=ue<=23: right-shift the 24-bit significand by 23-ue; g is the first bit shifted out, t is the OR of the rest.
  - ue>23: left-shift; g=t=0.
- Rounding: l = integer LSB. Increment the magnitude when:
  - RNe: g&(t|l);
  - RNa: g;
  - RU: (g|t)&!sign;
  - RD: (g|t)&sign;
  - RZ: never.
- inexact = g|t, unless the result is invalid.
- Signed results: negate the magnitude when sign=1.
  - Overflow: magnitude > 2^31-1 for positive, or > 2^31 for negative. This is checked after rounding.
  - On overflow: out=0x7FFFFFFF (positive or NaN) or 0x80000000 (negative); inv=1, inexact=0.
- Unsigned results:
  - Magnitude > 2^32-1, +Inf or NaN: out=0xFFFFFFFF, inv=1.
  - Negative with rounded magnitude != 0, or -Inf: out=0, inv=1.
  - Negative that rounds to 0 (e.g. -0.25): out=0, inv=0, inexact=1.
- Specials:
  - ±0 gives 0 with no flags.
  - Denormals are treated as ue<0 with t=1, so RU of a positive denormal gives 1 and RD of a negative denormal gives -1 (signed).
  - NaN (quiet or signalling) gives inv=1.

Optional Feature:
- Macro FP_TO_INT_INV_COUNT_EN.
- Defined: adds output port inv_count (16 bits). It is reset to 0 and increments, saturating at 0xFFFF, on every out_valid & out_ready transfer with inv=1.
- Undefined: the port and the counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/header: rounding-mode codes (RNe, RZ, RD, RU, RNa), FP special constants (FP_NANQ, FP_NANS, FP_INFP, FP_INFN, FP_ZEROP, FP_ZERON), exponent bias 127, and the integer saturation constants.
- One sub-module, fp_round_inc: combinational round-increment decision from (l, g, t, sign, round_m). It is shared later with the FP adder and multiplier.

Test Plan:
- 0x40200000 (2.5), signed -> RNe: 2; RNa: 3; RU: 3; RZ: 2; RD: 2. All with inexact=1, inv=0.
- 0xC0200000 (-2.5), signed, RD -> 0xFFFFFFFD (-3), inexact=1; same operand with RU -> 0xFFFFFFFE.
- Saturation and specials, signed:
  - 0x4F000000 -> 0x7FFFFFFF, inv=1;
  - 0xCF000000 -> 0x80000000, inv=0, inexact=0;
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, inv=1.
- Unsigned:
  - 0xBF800000 (-1.0) -> 0, inv=1;
  - 0xBE800000 (-0.25) with RZ -> 0, inv=0, inexact=1;
  - 0x4F800000 (2^32) -> 0xFFFFFFFF, inv=1.
- Backpressure: hold out_ready=0 and present 3 back-to-back operands.
  - Only 2 are accepted; in_ready=0 afterwards; out is held stable.
  - After out_ready=1, the results emerge in order on consecutive cycles.
- Reset mid-stream with v1=v2=1 -> out_valid=0 in the same cycle and out=0. After release, in_ready=1 and the next operand produces a result 2 cycles later.

Source files
------------

// File: rtl/fp_to_int_pkg.sv
// Shared constants and types for the FP-to-integer converter and its rounding helper.
package fp_to_int_pkg;

   localparam int unsigned BIAS = 127;

   localparam logic [2:0] RNE = 3'b000;
   localparam logic [2:0] RZ  = 3'b001;
   localparam logic [2:0] RD  = 3'b010;
   localparam logic [2:0] RU  = 3'b011;
   localparam logic [2:0] RNA = 3'b100;

   localparam logic [31:0] FP_NANQ  = 32'h7FC0_0000;
   localparam logic [31:0] FP_NANS  = 32'h7FA0_0000;
   localparam logic [31:0] FP_INFP  = 32'h7F80_0000;
   localparam logic [31:0] FP_INFN  = 32'hFF80_0000;
   localparam logic [31:0] FP_ZEROP = 32'h0000_0000;
   localparam logic [31:0] FP_ZERON = 32'h8000_0000;

   localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {ClsNorm, ClsZero, ClsDenorm, ClsInf, ClsNan, ClsOvf} fp_class_e;

   typedef struct packed {
      logic        sign;
      fp_class_e   cls;
      logic [31:0] ipart;
      logic        g;
      logic        t;
      logic [2:0]  round_m;
      logic        signed_m;
   } s1_t;

endpackage

// File: rtl/fp_to_int_if.sv
// Operand/result handshake bundle for fp_to_int; slave is the converter's view.
interface fp_to_int_if #(
   parameter int unsigned W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in1;
   logic [2:0]   round_m;
   logic         signed_m;
   logic [W-1:0] out;
   logic         out_valid;
   logic         out_ready;
   logic         inv;
   logic         inexact;

   modport slave (
      input  in_valid, in1, round_m, signed_m, out_ready,
      output in_ready, out, out_valid, inv, inexact
   );

   modport master (
      output in_valid, in1, round_m, signed_m, out_ready,
      input  in_ready, out, out_valid, inv, inexact
   );
endinterface

// File: rtl/fp_round_inc.sv
// Round-increment decision from LSB, guard, sticky, sign and rounding mode.
module fp_round_inc
   import fp_to_int_pkg::*;
(
   input  logic       l,
   input  logic       g,
   input  logic       t,
   input  logic       sign,
   input  logic [2:0] round_m,
   output logic       inc
);

   always_comb begin
      inc = 1'b0;
      case (round_m)
         RNE:     inc = g & (t | l);
         RNA:     inc = g;
         RU:      inc = (g | t) & ~sign;
         RD:      inc = (g | t) & sign;
         default: inc = 1'b0;  // RZ and unused codes truncate
      endcase
   end

endmodule

// File: rtl/fp_to_int.sv
// binary32 to int32/uint32 converter, two-stage elastic pipeline.
// Optional FP_TO_INT_INV_COUNT_EN adds a saturating count of invalid results delivered.
module fp_to_int
   import fp_to_int_pkg::*;
#(
   parameter int unsigned W = 32,
   parameter int unsigned M = 22,
   parameter int unsigned E = 30
) (
   input  logic       clk,
   input  logic       rst,
   fp_to_int_if.slave bus
`ifdef FP_TO_INT_INV_COUNT_EN
   ,
   output logic [15:0] inv_count
`endif
);

   logic v1_q, v2_q, s2_free, in_ready;
   s1_t  s1_d, s1_q;

   assign s2_free     = ~v2_q | bus.out_ready;
   assign in_ready    = ~v1_q | s2_free;
   assign bus.in_ready = in_ready;

   // Stage 1: unpack and align
   logic [E-M-1:0]    exp_in;
   logic [M:0]        mant;
   logic signed [9:0] ue;
   logic [54:0]       wide;

   assign exp_in = bus.in1[E:M+1];
   assign mant   = bus.in1[M:0];
   assign ue     = $signed({2'b00, exp_in} - 10'(BIAS));
   // Binary point sits between bits 23 and 22 after the shift.
   assign wide   = {31'b0, 1'b1, mant} << ue[4:0];

   always_comb begin
      s1_d          = '0;
      s1_d.cls      = ClsNorm;
      s1_d.sign     = bus.in1[W-1];
      s1_d.round_m  = bus.round_m;
      s1_d.signed_m = bus.signed_m;
      if (exp_in == '0) begin
         s1_d.cls = (mant == '0) ? ClsZero : ClsDenorm;
         s1_d.t   = (mant != '0);
      end else if (exp_in == '1) begin
         s1_d.cls = (mant != '0) ? ClsNan : ClsInf;
      end else if (ue > 10'sd31) begin
         s1_d.cls = ClsOvf;
      end else if (ue < 10'sd0) begin
         s1_d.g = (ue == -10'sd1);
         s1_d.t = (ue == -10'sd1) ? |mant : 1'b1;
      end else begin
         s1_d.ipart = wide[54:23];
         s1_d.g     = wide[22];
         s1_d.t     = |wide[21:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         s1_q <= '0;
      end else begin
         if (in_ready) v1_q <= bus.in_valid;
         if (bus.in_valid & in_ready) s1_q <= s1_d;
      end
   end

   // Stage 2: round, negate, saturate
   logic        inc, big;
   logic [32:0] mag;
   logic [31:0] out_d, out_q;
   logic        inv_d, inv_q, inexact_d, inexact_q;

   fp_round_inc u_round_inc (
      .l       (s1_q.ipart[0]),
      .g       (s1_q.g),
      .t       (s1_q.t),
      .sign    (s1_q.sign),
      .round_m (s1_q.round_m),
      .inc     (inc)
   );

   assign mag = {1'b0, s1_q.ipart} + {32'b0, inc};
   assign big = (s1_q.cls == ClsInf) | (s1_q.cls == ClsOvf);

   always_comb begin
      out_d     = '0;
      inv_d     = 1'b0;
      inexact_d = s1_q.g | s1_q.t;
      if (s1_q.signed_m) begin
         if (s1_q.cls == ClsNan || (!s1_q.sign && (big || mag > {1'b0, INT_MAX}))) begin
            out_d = INT_MAX;
            inv_d = 1'b1;
         end else if (s1_q.sign && (big || mag > {1'b0, INT_MIN})) begin
            out_d = INT_MIN;
            inv_d = 1'b1;
         end else begin
            out_d = s1_q.sign ? (~mag[31:0] + 32'd1) : mag[31:0];
         end
      end else begin
         if (s1_q.cls == ClsNan || (!s1_q.sign && (big || mag[32]))) begin
            out_d = UINT_MAX;
            inv_d = 1'b1;
         end else if (s1_q.sign && (big || mag != '0)) begin
            inv_d = 1'b1;
         end else begin
            out_d = mag[31:0];
         end
      end
      if (inv_d) inexact_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q      <= 1'b0;
         out_q     <= '0;
         inv_q     <= 1'b0;
         inexact_q <= 1'b0;
      end else if (s2_free) begin
         v2_q <= v1_q;
         if (v1_q) begin
            out_q     <= out_d;
            inv_q     <= inv_d;
            inexact_q <= inexact_d;
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = v2_q;
   assign bus.inv       = inv_q;
   assign bus.inexact   = inexact_q;

`ifdef FP_TO_INT_INV_COUNT_EN
   logic [15:0] inv_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inv_count_q <= '0;
      end else if (v2_q & bus.out_ready & inv_q & (inv_count_q != 16'hFFFF)) begin
         inv_count_q <= inv_count_q + 16'd1;
      end
   end

   assign inv_count = inv_count_q;
`endif

endmodule
